net_packet_dispatch: RTL and testbench

//  Parametrised network-side receiver for the core. Filters incoming net_packet_s
//  by destination ID (unicast or broadcast) and buffers accepted packets in a FIFO.

---
 rtl/net_packet_dispatch_pkg.sv | 44 ++++
 rtl/net_packet_dispatch_fifo.sv | 70 +++++++
 rtl/net_packet_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_net_packet_dispatch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// net_packet_dispatch_pkg
//   Shared definitions for the network-side packet receiver: the on-wire
//   packet layout, the operation codes carried in net_op, the dispatcher
//   state type and the broadcast destination ID.
// ---------------------------------------------------------------------------
package net_packet_dispatch_pkg;

  localparam int NET_ID_WIDTH   = 10;
  localparam int NET_OP_WIDTH   = 3;
  localparam int NET_RSVD_WIDTH = 6;
  localparam int NET_ADDR_WIDTH = 14;
  localparam int NET_DATA_WIDTH = 32;

  // A packet addressed to this ID is taken by every core.
  localparam logic [NET_ID_WIDTH-1:0] BCAST_ID = '1;

  // Codes 5..7 are not defined and count as illegal.
  typedef enum logic [NET_OP_WIDTH-1:0] {
    OP_NULL  = 3'd0,
    OP_INSTR = 3'd1,
    OP_REG   = 3'd2,
    OP_PC    = 3'd3,
    OP_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [NET_ID_WIDTH-1:0]   id;
    logic [NET_OP_WIDTH-1:0]   op;
    logic [NET_RSVD_WIDTH-1:0] rsvd;
    logic [NET_ADDR_WIDTH-1:0] addr;
    logic [NET_DATA_WIDTH-1:0] data;
  } net_packet_s;

  typedef enum logic {
    DISP = 1'b0,
    ERR  = 1'b1
  } dispatch_state_e;

  function automatic logic isLegalOp(input logic [NET_OP_WIDTH-1:0] op);
    return (op <= OP_BAR);
  endfunction

endpackage

// File: rtl/net_packet_dispatch_fifo.sv
// ---------------------------------------------------------------------------
// net_fifo
//   Small synchronous FIFO holding accepted packets until they are dispatched.
//   Ports:
//     clk, reset   clock and asynchronous active-high reset
//     push_i       write data_i this edge (ignored while full)
//     data_i       entry to write
//     pop_i        drop the head entry this edge (ignored while empty)
//     full_o       DEPTH entries held
//     empty_o      no entries held
//     head_o       oldest entry, valid while !empty_o
// ---------------------------------------------------------------------------
module net_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_WIDTH:0]   count_q;
  logic                 pushEn, popEn;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  // Gate requests here as well so the pointers can never overrun, whatever
  // the parent does. DEPTH is a power of two, so pointers wrap naturally.
  assign pushEn = push_i && !full_o;
  assign popEn  = pop_i && !empty_o;

  // Storage needs no reset: stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + PTR_WIDTH'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + PTR_WIDTH'(1);
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + (PTR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (PTR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/net_packet_dispatch.sv
// ---------------------------------------------------------------------------
// net_packet_dispatch
//   Network-side receiver for the core. Filters packets by destination ID
//   (own ID or broadcast), queues accepted ones and dispatches each as a
//   one-cycle write strobe to imem, register file, PC or barrier mask.
//   Ports:
//     clk, reset        clock and asynchronous active-high reset
//     my_id_i           this core's network ID
//     pkt_valid_i/pkt_i incoming packet {ID, net_op, reserved, addr, data}
//     pkt_ready_o       queue has room; transfer on valid & ready
//     sink_ready_i      core can take a dispatch this cycle
//     clear_err_i       leave the error state
//     *_we_o + fields   registered dispatch strobes with their addr/data
//     err_o             high while stopped on an illegal op
//     drop_cnt_o        saturating count of packets for other cores
// ---------------------------------------------------------------------------
module net_packet_dispatch
  import net_packet_dispatch_pkg::*;
#(
  parameter int ID_WIDTH        = 10,
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int MASK_WIDTH      = 3,
  parameter bit STRICT          = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ID_WIDTH-1:0]        my_id_i,
  input  logic                       pkt_valid_i,
  input  logic [ID_WIDTH+NET_OP_WIDTH+NET_RSVD_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] pkt_i,
  output logic                       pkt_ready_o,
  input  logic                       sink_ready_i,
  input  logic                       clear_err_i,
  output logic                       imem_we_o,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
  output logic [15:0]                imem_wdata_o,
  output logic                       rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]   rf_addr_o,
  output logic [DATA_WIDTH-1:0]      rf_wdata_o,
  output logic                       pc_we_o,
  output logic [IMEM_ADDR_WIDTH-1:0] pc_o,
  output logic                       bar_we_o,
  output logic [MASK_WIDTH-1:0]      bar_mask_o,
  output logic                       err_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int OP_WIDTH    = NET_OP_WIDTH;
  localparam int RSVD_WIDTH  = NET_RSVD_WIDTH;
  localparam int PKT_WIDTH   = ID_WIDTH + OP_WIDTH + RSVD_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int ENTRY_WIDTH = OP_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ID_WIDTH-1:0] BCAST = '1;

  logic [ID_WIDTH-1:0]    pktId;
  logic [OP_WIDTH-1:0]    pktOp;
  logic [RSVD_WIDTH-1:0]  pktRsvd;
  logic [ENTRY_WIDTH-1:0] pktEntry, head;
  logic [OP_WIDTH-1:0]    headOp;
  logic [ADDR_WIDTH-1:0]  headAddr;
  logic [DATA_WIDTH-1:0]  headData;
  logic fifoFull, fifoEmpty, transfer, idMatch, doPush, doPop;
  logic unusedBits;

  dispatch_state_e state_q, state_d;
  logic [7:0] dropCnt_q, dropCnt_d;
  logic imemWe_q, imemWe_d, rfWe_q, rfWe_d, pcWe_q, pcWe_d, barWe_q, barWe_d;
  logic [IMEM_ADDR_WIDTH-1:0] imemAddr_q, imemAddr_d, pc_q, pc_d;
  logic [15:0]                imemWdata_q, imemWdata_d;
  logic [RF_ADDR_WIDTH-1:0]   rfAddr_q, rfAddr_d;
  logic [DATA_WIDTH-1:0]      rfWdata_q, rfWdata_d;
  logic [MASK_WIDTH-1:0]      barMask_q, barMask_d;

  // Only op/addr/data are queued; ID and reserved bits are consumed on entry.
  assign pktId    = pkt_i[PKT_WIDTH-1 -: ID_WIDTH];
  assign pktOp    = pkt_i[DATA_WIDTH+ADDR_WIDTH+RSVD_WIDTH +: OP_WIDTH];
  assign pktRsvd  = pkt_i[DATA_WIDTH+ADDR_WIDTH +: RSVD_WIDTH];
  assign pktEntry = {pktOp, pkt_i[DATA_WIDTH+ADDR_WIDTH-1:0]};
  assign headOp   = head[ENTRY_WIDTH-1 -: OP_WIDTH];
  assign headAddr = head[DATA_WIDTH +: ADDR_WIDTH];
  assign headData = head[DATA_WIDTH-1:0];
  assign unusedBits = ^{pktRsvd, headAddr, headData};

  // Ready depends only on occupancy, so a full queue refuses a packet even
  // on an edge where it also pops.
  assign pkt_ready_o = !fifoFull;
  assign transfer    = pkt_valid_i && pkt_ready_o;
  assign idMatch     = (pktId == my_id_i) || (pktId == BCAST);
  assign doPush      = transfer && idMatch;
  assign doPop       = (state_q == DISP) && !fifoEmpty && sink_ready_i;

  net_fifo #(
    .WIDTH(ENTRY_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (doPush),
    .data_i (pktEntry),
    .pop_i  (doPop),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .head_o (head)
  );

  // Decode the popped head into one strobe for the next cycle; each strobe's
  // fields are only replaced by a dispatch of the same kind.
  always_comb begin
    state_d     = state_q;
    dropCnt_d   = dropCnt_q;
    imemWe_d    = 1'b0;
    rfWe_d      = 1'b0;
    pcWe_d      = 1'b0;
    barWe_d     = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;
    rfAddr_d    = rfAddr_q;
    rfWdata_d   = rfWdata_q;
    pc_d        = pc_q;
    barMask_d   = barMask_q;

    if (transfer && !idMatch && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end

    case (state_q)
      DISP: begin
        if (doPop) begin
          case (headOp)
            OP_NULL: ;
            OP_INSTR: begin
              imemWe_d    = 1'b1;
              imemAddr_d  = headAddr[IMEM_ADDR_WIDTH-1:0];
              imemWdata_d = headData[15:0];
            end
            OP_REG: begin
              rfWe_d    = 1'b1;
              rfAddr_d  = headAddr[RF_ADDR_WIDTH-1:0];
              rfWdata_d = headData;
            end
            OP_PC: begin
              pcWe_d = 1'b1;
              pc_d   = headData[IMEM_ADDR_WIDTH-1:0];
            end
            OP_BAR: begin
              barWe_d   = 1'b1;
              barMask_d = headData[MASK_WIDTH-1:0];
            end
            default: begin
              if (STRICT && !isLegalOp(headOp)) state_d = ERR;
            end
          endcase
        end
      end
      ERR: begin
        if (clear_err_i) state_d = DISP;
      end
    endcase
  end

  // All dispatcher state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DISP;
      dropCnt_q   <= '0;
      imemWe_q    <= 1'b0;
      rfWe_q      <= 1'b0;
      pcWe_q      <= 1'b0;
      barWe_q     <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      rfAddr_q    <= '0;
      rfWdata_q   <= '0;
      pc_q        <= '0;
      barMask_q   <= '0;
    end else begin
      state_q     <= state_d;
      dropCnt_q   <= dropCnt_d;
      imemWe_q    <= imemWe_d;
      rfWe_q      <= rfWe_d;
      pcWe_q      <= pcWe_d;
      barWe_q     <= barWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
      rfAddr_q    <= rfAddr_d;
      rfWdata_q   <= rfWdata_d;
      pc_q        <= pc_d;
      barMask_q   <= barMask_d;
    end
  end

  assign imem_we_o    = imemWe_q;
  assign imem_addr_o  = imemAddr_q;
  assign imem_wdata_o = imemWdata_q;
  assign rf_we_o      = rfWe_q;
  assign rf_addr_o    = rfAddr_q;
  assign rf_wdata_o   = rfWdata_q;
  assign pc_we_o      = pcWe_q;
  assign pc_o         = pc_q;
  assign bar_we_o     = barWe_q;
  assign bar_mask_o   = barMask_q;
  assign err_o        = (state_q == ERR);
  assign drop_cnt_o   = dropCnt_q;

endmodule

// File: tb/tb_net_packet_dispatch.sv
// ---------------------------------------------------------------------------
// tb_net_packet_dispatch
//   Directed bench for net_packet_dispatch with a queue-based reference model
//   and a per-cycle comparison of every output.
// ---------------------------------------------------------------------------
module tb_net_packet_dispatch;
  import net_packet_dispatch_pkg::*;

  localparam int PKT_W = $bits(net_packet_s);
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [9:0]       my_id;
  logic             pkt_valid;
  logic [PKT_W-1:0] pkt;
  logic             sink_ready;
  logic             clear_err;
  logic             pkt_ready_o, imem_we_o, rf_we_o, pc_we_o, bar_we_o, err_o;
  logic [9:0]       imem_addr_o, pc_o;
  logic [15:0]      imem_wdata_o;
  logic [4:0]       rf_addr_o;
  logic [31:0]      rf_wdata_o;
  logic [2:0]       bar_mask_o;
  logic [7:0]       drop_cnt_o;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;
  int imemPulses = 0, rfPulses = 0, pcPulses = 0, barPulses = 0;
  int base;

  net_packet_dispatch #(.STRICT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .my_id_i     (my_id),
    .pkt_valid_i (pkt_valid),
    .pkt_i       (pkt),
    .pkt_ready_o (pkt_ready_o),
    .sink_ready_i(sink_ready),
    .clear_err_i (clear_err),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .rf_we_o     (rf_we_o),
    .rf_addr_o   (rf_addr_o),
    .rf_wdata_o  (rf_wdata_o),
    .pc_we_o     (pc_we_o),
    .pc_o        (pc_o),
    .bar_we_o    (bar_we_o),
    .bar_mask_o  (bar_mask_o),
    .err_o       (err_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PKT_W-1:0] mkPkt(input logic [9:0] id, input logic [2:0] op,
                                             input logic [13:0] addr, input logic [31:0] data);
    net_packet_s p;
    p.id   = id;
    p.op   = op;
    p.rsvd = 6'h2A;
    p.addr = addr;
    p.data = data;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [PKT_W-1:0] p, input logic s, input logic c);
    @(negedge clk);
    pkt_valid  = v;
    pkt        = p;
    sink_ready = s;
    clear_err  = c;
  endtask

  task automatic idleCycles(input int n, input logic s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, s, 1'b0);
  endtask

  // Reference model: a plain packet queue, updated with the inputs seen at
  // each rising edge.
  net_packet_s mq[$];
  net_packet_s mHead, mIn;
  bit          mPop, mRoom;
  logic        mErr;
  logic [7:0]  mDrop;
  logic        mImemWe, mRfWe, mPcWe, mBarWe;
  logic [9:0]  mImemAddr, mPc;
  logic [15:0] mImemWdata;
  logic [4:0]  mRfAddr;
  logic [31:0] mRfWdata;
  logic [2:0]  mBarMask;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mErr = 0; mDrop = 0;
      mImemWe = 0; mRfWe = 0; mPcWe = 0; mBarWe = 0;
      mImemAddr = 0; mImemWdata = 0; mRfAddr = 0; mRfWdata = 0; mPc = 0; mBarMask = 0;
    end else begin
      mPop  = !mErr && (mq.size() > 0) && sink_ready;
      mRoom = mq.size() < DEPTH;
      mImemWe = 0; mRfWe = 0; mPcWe = 0; mBarWe = 0;
      if (mErr) begin
        if (clear_err) mErr = 0;
      end else if (mPop) begin
        mHead = mq.pop_front();
        if (mHead.op == 3'd1) begin
          mImemWe = 1; mImemAddr = mHead.addr[9:0]; mImemWdata = mHead.data[15:0];
        end else if (mHead.op == 3'd2) begin
          mRfWe = 1; mRfAddr = mHead.addr[4:0]; mRfWdata = mHead.data;
        end else if (mHead.op == 3'd3) begin
          mPcWe = 1; mPc = mHead.data[9:0];
        end else if (mHead.op == 3'd4) begin
          mBarWe = 1; mBarMask = mHead.data[2:0];
        end else if (mHead.op >= 3'd5) begin
          mErr = 1;
        end
      end
      if (pkt_valid && mRoom) begin
        mIn = pkt;
        if (mIn.id == my_id || mIn.id == BCAST_ID) mq.push_back(mIn);
        else if (mDrop != 8'd255) mDrop = mDrop + 8'd1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset && checkEn) begin
      checkOutput("cmp_pkt_ready", pkt_ready_o, mq.size() < DEPTH);
      checkOutput("cmp_err", err_o, mErr);
      checkOutput("cmp_drop_cnt", drop_cnt_o, mDrop);
      checkOutput("cmp_imem_we", imem_we_o, mImemWe);
      checkOutput("cmp_imem_addr", imem_addr_o, mImemAddr);
      checkOutput("cmp_imem_wdata", imem_wdata_o, mImemWdata);
      checkOutput("cmp_rf_we", rf_we_o, mRfWe);
      checkOutput("cmp_rf_addr", rf_addr_o, mRfAddr);
      checkOutput("cmp_rf_wdata", rf_wdata_o, mRfWdata);
      checkOutput("cmp_pc_we", pc_we_o, mPcWe);
      checkOutput("cmp_pc", pc_o, mPc);
      checkOutput("cmp_bar_we", bar_we_o, mBarWe);
      checkOutput("cmp_bar_mask", bar_mask_o, mBarMask);
    end
  end

  // Strobe pulse counters used by the directed checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we_o) imemPulses++;
      if (rf_we_o)   rfPulses++;
      if (pc_we_o)   pcPulses++;
      if (bar_we_o)  barPulses++;
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    reset = 1'b1; my_id = 10'd3; pkt_valid = 0; pkt = '0; sink_ready = 0; clear_err = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkEn = 1;
    checkOutput("reset_pkt_ready", pkt_ready_o, 1);
    checkOutput("reset_err", err_o, 0);
    checkOutput("reset_drop", drop_cnt_o, 0);
    checkOutput("reset_imem_we", imem_we_o, 0);

    // Unicast INSTR: strobe in the cycle after the pop edge.
    applyStimulus(1'b1, mkPkt(10'd3, 3'd1, 14'h005, 32'h0000ABCD), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("instr_not_yet", imem_we_o, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("instr_we", imem_we_o, 1);
    checkOutput("instr_addr", imem_addr_o, 10'h005);
    checkOutput("instr_wdata", imem_wdata_o, 16'hABCD);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("instr_one_cycle", imem_we_o, 0);
    checkOutput("instr_addr_held", imem_addr_o, 10'h005);

    // Broadcast REG, then a packet for another core.
    applyStimulus(1'b1, mkPkt(10'h3FF, 3'd2, 14'h007, 32'hDEADBEEF), 1'b1, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("bcast_rf_pulses", rfPulses, 1);
    checkOutput("bcast_rf_addr", rf_addr_o, 5'd7);
    checkOutput("bcast_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
    applyStimulus(1'b1, mkPkt(10'd9, 3'd2, 14'h008, 32'h1), 1'b1, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("mismatch_drop1", drop_cnt_o, 1);
    checkOutput("mismatch_no_strobe", rfPulses, 1);

    // 300 mismatches in total saturate the counter.
    for (int i = 0; i < 299; i++) applyStimulus(1'b1, mkPkt(10'd9, 3'd3, 14'h0, 32'h0), 1'b1, 1'b0);
    idleCycles(2, 1'b1);
    checkOutput("drop_saturate", drop_cnt_o, 255);

    // Fill with the sink stalled, then drain one per cycle in order.
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, mkPkt(10'd3, 3'd2, 14'(k), 32'h100 + k), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_not_ready", pkt_ready_o, 0);
    checkOutput("stalled_no_strobe", rf_we_o, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain_we", rf_we_o, 1);
      checkOutput("drain_addr", rf_addr_o, k);
      checkOutput("drain_data", rf_wdata_o, 32'h100 + k);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_done", rf_we_o, 0);

    // Full queue with pop and valid on the same edge: no accept, count 3.
    base = rfPulses;
    for (int k = 11; k <= 14; k++)
      applyStimulus(1'b1, mkPkt(10'd3, 3'd2, 14'(k), 32'h200 + k), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(10'd3, 3'd2, 14'd20, 32'h220), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_pop_ready", pkt_ready_o, 1);
    applyStimulus(1'b1, mkPkt(10'd3, 3'd2, 14'd21, 32'h221), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("refill_not_ready", pkt_ready_o, 0);
    idleCycles(7, 1'b1);
    checkOutput("full_pop_pulses", rfPulses - base, 5);
    checkOutput("full_pop_last", rf_addr_o, 5'd21);

    // Illegal op stops dispatch until cleared.
    applyStimulus(1'b1, mkPkt(10'd3, 3'd6, 14'h0, 32'h0), 1'b1, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("illegal_err", err_o, 1);
    applyStimulus(1'b1, mkPkt(10'd3, 3'd4, 14'h0, 32'h5), 1'b1, 1'b0);
    idleCycles(4, 1'b1);
    checkOutput("err_no_bar", barPulses, 0);
    checkOutput("err_still", err_o, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("clear_err", err_o, 0);
    checkOutput("clear_bar_pulses", barPulses, 1);
    checkOutput("clear_bar_mask", bar_mask_o, 3'b101);

    // Reset with two packets queued.
    applyStimulus(1'b1, mkPkt(10'd3, 3'd3, 14'h0, 32'h55), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(10'd3, 3'd3, 14'h0, 32'h66), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_pkt_ready", pkt_ready_o, 1);
    checkOutput("rst_drop", drop_cnt_o, 0);
    checkOutput("rst_bar_mask", bar_mask_o, 0);
    checkOutput("rst_rf_addr", rf_addr_o, 0);
    @(negedge clk);
    reset = 1'b0;
    idleCycles(4, 1'b1);
    checkOutput("rst_no_pc", pcPulses, 0);
    checkOutput("rst_ready_after", pkt_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
